// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID-stage hazard logic: opcode constants,
// the hazard FSM state type, the decoded-field bundle and a register-match helper.
package mips_pkg;

    // Opcodes the hazard logic needs to recognise
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // RUN: normal hazard evaluation; STALL2: second cycle of a lw -> branch stall
    typedef enum logic {
        RUN    = 1'b0,
        STALL2 = 1'b1
    } hazard_state_t;

    // Fields and register usage extracted from one pipeline register's instruction
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] dest;
        logic       reads_rs;
        logic       reads_rt;
        logic       is_branch;
        logic       is_jump;
    } decode_t;

    // $0 is hard-wired to zero, so it can never carry a dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Purely combinational field decoder for one pipeline register's instruction.
// Produces the register fields, the destination register, which sources the
// instruction actually reads, and branch/jump classification.
module hazard_decode
    import mips_pkg::*;
(
    input  logic [31:0] instru,
    output decode_t     fields
);

    logic instru_unused;

    // The shamt/funct bits never influence hazard detection
    assign instru_unused = ^instru[10:0];

    // Split the instruction into fields and classify its register usage
    always_comb begin
        fields           = '0;
        fields.opcode    = instru[31:26];
        fields.rs        = instru[25:21];
        fields.rt        = instru[20:16];
        fields.rd        = instru[15:11];
        fields.dest      = (instru[31:26] == OP_RTYPE) ? instru[15:11] : instru[20:16];
        fields.reads_rs  = (instru[31:26] != OP_J);
        fields.reads_rt  = (instru[31:26] == OP_RTYPE) || (instru[31:26] == OP_SW) ||
                           (instru[31:26] == OP_BEQ)   || (instru[31:26] == OP_BNE);
        fields.is_branch = (instru[31:26] == OP_BEQ) || (instru[31:26] == OP_BNE);
        fields.is_jump   = (instru[31:26] == OP_J);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use and branch-operand hazards against ID/EX and EX/MEM,
// stalls PC and IF/ID, bubbles ID/EX, and flushes IF/ID on taken branches
// and jumps. A lw feeding a beq/bne is sequenced by a RUN/STALL2 FSM.
// Optional feature macro: HAZARD_PERF_EN adds stall_cnt/flush_cnt counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       id_instru,
    input  logic [31:0]       ex_instru,
    input  logic [31:0]       ex_mem_instru,
    input  logic              c_id_ex_MemRead,
    input  logic              c_id_ex_RegWrite,
    input  logic              c_ex_mem_MemRead,
    input  logic              c_branch_taken,
    output logic              c_pc_write,
    output logic              c_if_id_write,
    output logic              c_id_ex_bubble,
    output logic              c_if_id_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    decode_t       id_f;
    decode_t       ex_f;
    decode_t       ex_mem_f;
    hazard_state_t state;
    hazard_state_t state_next;

    logic lu;
    logic br_alu;
    logic br_ld1;
    logic br_ld2;
    logic stall;
    logic flush;
    logic decode_unused;

    hazard_decode u_dec_id (
        .instru (id_instru),
        .fields (id_f)
    );

    hazard_decode u_dec_ex (
        .instru (ex_instru),
        .fields (ex_f)
    );

    hazard_decode u_dec_ex_mem (
        .instru (ex_mem_instru),
        .fields (ex_mem_f)
    );

    // Not every decoded field is consumed from every pipeline register
    assign decode_unused = ^{id_f, ex_f, ex_mem_f};

    // Combinational hazard terms from the three pipeline registers
    always_comb begin
        lu     = 1'b0;
        br_alu = 1'b0;
        br_ld1 = 1'b0;
        br_ld2 = 1'b0;

        lu = c_id_ex_MemRead &&
             ((id_f.reads_rs && reg_match(ex_f.rt, id_f.rs)) ||
              (id_f.reads_rt && reg_match(ex_f.rt, id_f.rt)));

        br_alu = id_f.is_branch && c_id_ex_RegWrite && !c_id_ex_MemRead &&
                 (reg_match(ex_f.dest, id_f.rs) || reg_match(ex_f.dest, id_f.rt));

        br_ld1 = id_f.is_branch && lu;

        br_ld2 = id_f.is_branch && c_ex_mem_MemRead &&
                 (reg_match(ex_mem_f.rt, id_f.rs) || reg_match(ex_mem_f.rt, id_f.rt));
    end

    // Stall and flush decisions; an unresolved branch must never flush
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;

        stall = lu || br_alu || br_ld2 || (state == STALL2);
        flush = !stall && ((id_f.is_branch && c_branch_taken) || id_f.is_jump);
    end

    // Hazard FSM state register, synchronously returned to RUN by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a lw feeding a branch needs a second guaranteed stall cycle
    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = br_ld1 ? STALL2 : RUN;
            STALL2:  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Pipeline control outputs, forced to a safe hold/flush pattern in reset
    always_comb begin
        c_pc_write     = 1'b1;
        c_if_id_write  = 1'b1;
        c_id_ex_bubble = 1'b0;
        c_if_id_flush  = 1'b0;

        if (!rst_n) begin
            c_pc_write     = 1'b0;
            c_if_id_write  = 1'b0;
            c_id_ex_bubble = 1'b1;
            c_if_id_flush  = 1'b1;
        end else begin
            c_pc_write     = !stall;
            c_if_id_write  = !stall;
            c_id_ex_bubble = stall;
            c_if_id_flush  = flush;
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: stall cycles and flush cycles, wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (flush) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end
`else
    // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Each step drives one cycle of
// pipeline-register contents and compares the control outputs against
// hand-computed values. Counter checks are compiled only with HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int PERF_W = 32;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [31:0] LW_2_1      = 32'h8C22_0000; // lw  $2,0($1)
    localparam logic [31:0] ADD_3_2_4   = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] ADD_2_5_6   = 32'h00A6_1020; // add $2,$5,$6
    localparam logic [31:0] BEQ_2_3     = 32'h1043_0004; // beq $2,$3
    localparam logic [31:0] J_TGT       = 32'h0800_0010; // j
    localparam logic [31:0] J_RS1       = 32'h0822_0000; // j with nonzero rs/rt bits
    localparam logic [31:0] LW_0_1      = 32'h8C20_0000; // lw  $0,0($1)
    localparam logic [31:0] ADD_3_0_0   = 32'h0000_1820; // add $3,$0,$0
    localparam logic [31:0] SW_2_1      = 32'hAC22_0000; // sw  $2,0($1)
    localparam logic [31:0] LW_5_2      = 32'h8C45_0000; // lw  $5,0($2)
    localparam logic [31:0] LW_2_7      = 32'h8CE2_0000; // lw  $2,0($7)
    localparam logic [31:0] LW_3_1      = 32'h8C23_0000; // lw  $3,0($1)
    localparam logic [31:0] LW_1_0      = 32'h8C01_0000; // lw  $1,0($0)

    logic              clk;
    logic              rst_n;
    logic [31:0]       id_instru;
    logic [31:0]       ex_instru;
    logic [31:0]       ex_mem_instru;
    logic              c_id_ex_MemRead;
    logic              c_id_ex_RegWrite;
    logic              c_ex_mem_MemRead;
    logic              c_branch_taken;
    logic              c_pc_write;
    logic              c_if_id_write;
    logic              c_id_ex_bubble;
    logic              c_if_id_flush;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .PERF_W (PERF_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_instru        (id_instru),
        .ex_instru        (ex_instru),
        .ex_mem_instru    (ex_mem_instru),
        .c_id_ex_MemRead  (c_id_ex_MemRead),
        .c_id_ex_RegWrite (c_id_ex_RegWrite),
        .c_ex_mem_MemRead (c_ex_mem_MemRead),
        .c_branch_taken   (c_branch_taken),
        .c_pc_write       (c_pc_write),
        .c_if_id_write    (c_if_id_write),
        .c_id_ex_bubble   (c_id_ex_bubble),
        .c_if_id_flush    (c_if_id_flush)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then let them settle
    task automatic applyStimulus(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                                 input logic [31:0] exmem, input logic ex_rd, input logic ex_wr,
                                 input logic exmem_rd, input logic taken);
        @(negedge clk);
        rst_n            = rst;
        id_instru        = id;
        ex_instru        = ex;
        ex_mem_instru    = exmem;
        c_id_ex_MemRead  = ex_rd;
        c_id_ex_RegWrite = ex_wr;
        c_ex_mem_MemRead = exmem_rd;
        c_branch_taken   = taken;
        #1;
    endtask

    // Compare all four control outputs with the expected values
    task automatic checkOutput(input string tag, input logic pc, input logic ifid,
                               input logic bubble, input logic flush);
        checks++;
        assert (c_pc_write === pc) else begin
            failures++;
            $error("[TB] FAIL %s c_pc_write observed=%0b expected=%0b", tag, c_pc_write, pc);
        end
        checks++;
        assert (c_if_id_write === ifid) else begin
            failures++;
            $error("[TB] FAIL %s c_if_id_write observed=%0b expected=%0b", tag, c_if_id_write, ifid);
        end
        checks++;
        assert (c_id_ex_bubble === bubble) else begin
            failures++;
            $error("[TB] FAIL %s c_id_ex_bubble observed=%0b expected=%0b", tag, c_id_ex_bubble, bubble);
        end
        checks++;
        assert (c_if_id_flush === flush) else begin
            failures++;
            $error("[TB] FAIL %s c_if_id_flush observed=%0b expected=%0b", tag, c_if_id_flush, flush);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic checkCounters(input string tag, input logic [PERF_W-1:0] s,
                                 input logic [PERF_W-1:0] f);
        checks++;
        assert (stall_cnt === s) else begin
            failures++;
            $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, s);
        end
        checks++;
        assert (flush_cnt === f) else begin
            failures++;
            $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, f);
        end
    endtask
`endif

    // Directed sequence: each step is one clock cycle of pipeline contents
    initial begin
        rst_n = 1'b0; id_instru = NOP; ex_instru = NOP; ex_mem_instru = NOP;
        c_id_ex_MemRead = 1'b0; c_id_ex_RegWrite = 1'b0;
        c_ex_mem_MemRead = 1'b0; c_branch_taken = 1'b0;

        // Reset holds the front end and flushes
        applyStimulus(1'b0, NOP, NOP, NOP, 0, 0, 0, 0);
        applyStimulus(1'b0, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("reset_hold", 0, 0, 1, 1);

        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("idle_nops", 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        checkCounters("reset_counters", 0, 0);
`endif

        // lw -> dependent add: one stall cycle
        applyStimulus(1'b1, ADD_3_2_4, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("lu_stall", 0, 0, 1, 0);
        applyStimulus(1'b1, ADD_3_2_4, NOP, LW_2_1, 0, 0, 1, 0);
        checkOutput("lu_release", 1, 1, 0, 0);

        // add -> dependent beq: one stall, taken flag ignored while stalled
        applyStimulus(1'b1, BEQ_2_3, ADD_2_5_6, NOP, 0, 1, 0, 1);
        checkOutput("br_alu_stall", 0, 0, 1, 0);
        applyStimulus(1'b1, BEQ_2_3, NOP, ADD_2_5_6, 0, 0, 0, 1);
        checkOutput("br_alu_taken", 1, 1, 0, 1);
        applyStimulus(1'b1, BEQ_2_3, NOP, NOP, 0, 0, 0, 0);
        checkOutput("br_not_taken", 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        checkCounters("counts_mid", 2, 1);
`endif

        // Clear counters, then lw -> dependent beq: exactly two stalls
        applyStimulus(1'b0, NOP, NOP, NOP, 0, 0, 0, 0);
        applyStimulus(1'b1, BEQ_2_3, LW_2_1, NOP, 1, 1, 0, 1);
        checkOutput("br_ld_stall1", 0, 0, 1, 0);
        applyStimulus(1'b1, BEQ_2_3, NOP, LW_2_1, 0, 0, 1, 1);
        checkOutput("br_ld_stall2", 0, 0, 1, 0);
        applyStimulus(1'b1, BEQ_2_3, NOP, NOP, 0, 0, 0, 1);
        checkOutput("br_ld_resolve", 1, 1, 0, 1);
        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("br_ld_after", 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        checkCounters("br_ld_counts", 2, 1);
`endif

        // STALL2 stalls even when the inputs show no hazard
        applyStimulus(1'b1, BEQ_2_3, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("forced_a", 0, 0, 1, 0);
        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("forced_stall2", 0, 0, 1, 0);
        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("forced_done", 1, 1, 0, 0);

        // Reset in STALL2 aborts the stall with no residue
        applyStimulus(1'b1, BEQ_2_3, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("abort_a", 0, 0, 1, 0);
        applyStimulus(1'b0, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("abort_reset", 0, 0, 1, 1);
        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("abort_release", 1, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        checkCounters("abort_counters", 0, 0);
`endif

        // Jump flushes without stalling, even with matching-looking fields
        applyStimulus(1'b1, J_TGT, NOP, NOP, 0, 0, 0, 0);
        checkOutput("jump_flush", 1, 1, 0, 1);
        applyStimulus(1'b1, J_RS1, LW_1_0, NOP, 1, 1, 0, 0);
        checkOutput("jump_no_rs", 1, 1, 0, 1);

        // $0 never creates a dependency
        applyStimulus(1'b1, ADD_3_0_0, LW_0_1, NOP, 1, 1, 0, 0);
        checkOutput("zero_reg", 1, 1, 0, 0);

        // Source usage: sw reads rt, lw reads rs but not rt
        applyStimulus(1'b1, SW_2_1, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("sw_rt_stall", 0, 0, 1, 0);
        applyStimulus(1'b1, LW_5_2, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("lw_rs_stall", 0, 0, 1, 0);
        applyStimulus(1'b1, LW_2_7, LW_2_1, NOP, 1, 1, 0, 0);
        checkOutput("lw_rt_unread", 1, 1, 0, 0);

        // EX/MEM lw feeding a branch's rt stalls without entering STALL2
        applyStimulus(1'b1, BEQ_2_3, NOP, LW_3_1, 0, 0, 1, 1);
        checkOutput("br_ld2_only", 0, 0, 1, 0);
        applyStimulus(1'b1, NOP, NOP, NOP, 0, 0, 0, 0);
        checkOutput("br_ld2_after", 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
